// File: rtl/clause_pkg.sv
// Shared clause/engine sizing and types for the clause dispatch path.
// No logic; constants and typedefs only.
// No flow control of its own.
package clause_pkg;
    localparam int LIT_IDX_MAX = 1024;
    localparam int CLA_LENGTH  = 3;
    localparam int NUM_ENGINE  = 4;
    localparam int VAR_W       = $clog2(LIT_IDX_MAX) + 1;
    localparam int CLA_W       = CLA_LENGTH * VAR_W;
    localparam int ENG_CNT_W   = $clog2(NUM_ENGINE) + 1;

    typedef logic [CLA_W-1:0]     clause_t;
    typedef logic [ENG_CNT_W-1:0] eng_cnt_t;
endpackage

// File: rtl/clause_dispatch_queue.sv
// Circular clause buffer: presents the oldest NUM_ENGINE clauses to the arbiter, retires accepted ones.
// Latency 1: a pushed clause appears on clause_out the cycle after it is accepted.
// ready_out drops when full (no same-cycle pop bypass); over-accept and post-load pushes set sticky err.
module clause_dispatch_queue
    import clause_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [CLA_W-1:0]                    clause_in,
    input  logic                                clause_valid_in,
    output logic                                ready_out,
    input  logic                                load_done_in,
    output logic [NUM_ENGINE-1:0][CLA_W-1:0]    clause_out,
    output logic [ENG_CNT_W-1:0]                clause_cnt_out,
    input  logic [ENG_CNT_W-1:0]                accept_in,
    output logic [$clog2(DEPTH):0]              count_out,
    output logic                                done_out,
    output logic                                err_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage is never cleared; stale entries are hidden by count.
    clause_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             loaded;
    logic             err;

    logic             full;
    logic             push;
    logic             over;
    logic             drop_err;
    eng_cnt_t         win_cnt;
    eng_cnt_t         n_eff;

    // Push/pop qualification from current state; retire count is clamped to the visible window.
    always_comb begin
        full     = (count == CNT_W'(DEPTH));
        push     = clause_valid_in && !full && !loaded;
        if (count >= CNT_W'(NUM_ENGINE)) begin
            win_cnt = eng_cnt_t'(NUM_ENGINE);
        end else begin
            win_cnt = eng_cnt_t'(count);
        end
        over     = (accept_in > win_cnt);
        n_eff    = over ? win_cnt : accept_in;
        drop_err = clause_valid_in && loaded;
    end

    // Pointer, occupancy and sticky flag state.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            loaded <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr + PTR_W'(n_eff);
            count  <= count + CNT_W'(push) - CNT_W'(n_eff);
            if (load_done_in) begin
                loaded <= 1'b1;
            end
            if (over || drop_err) begin
                err <= 1'b1;
            end
        end
    end

    // Clause storage write.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= clause_in;
        end
    end

    // Presentation window: slot k is the k-th oldest entry, zero beyond the valid count.
    always_comb begin
        for (int k = 0; k < NUM_ENGINE; k++) begin
            clause_out[k] = '0;
            if (eng_cnt_t'(k) < win_cnt) begin
                clause_out[k] = mem[rd_ptr + PTR_W'(k)];
            end
        end
    end

    assign ready_out      = !full;
    assign clause_cnt_out = win_cnt;
    assign count_out      = count;
    assign done_out       = loaded && (count == '0);
    assign err_out        = err;
endmodule

// File: tb/tb_clause_dispatch_queue.sv
module tb_clause_dispatch_queue;
    import clause_pkg::*;

    localparam int DEPTH = 16;

    logic                             clock = 1'b0;
    logic                             reset;
    clause_t                          clause_in;
    logic                             clause_valid_in;
    logic                             ready_out;
    logic                             load_done_in;
    logic [NUM_ENGINE-1:0][CLA_W-1:0] clause_out;
    eng_cnt_t                         clause_cnt_out;
    eng_cnt_t                         accept_in;
    logic [$clog2(DEPTH):0]           count_out;
    logic                             done_out;
    logic                             err_out;

    clause_dispatch_queue #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .clause_in      (clause_in),
        .clause_valid_in(clause_valid_in),
        .ready_out      (ready_out),
        .load_done_in   (load_done_in),
        .clause_out     (clause_out),
        .clause_cnt_out (clause_cnt_out),
        .accept_in      (accept_in),
        .count_out      (count_out),
        .done_out       (done_out),
        .err_out        (err_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic    rdy;
        int      cnt;
        int      count;
        logic    done;
        logic    err;
        clause_t slot [NUM_ENGINE];
    } exp_t;

    exp_t    exp_q[$];
    clause_t mq[$];
    bit      m_loaded = 0;
    bit      m_err    = 0;
    int      total    = 0;
    int      bad      = 0;

    function automatic int min_int(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        int   w;
        w       = min_int(mq.size(), NUM_ENGINE);
        e.rdy   = (mq.size() != DEPTH);
        e.cnt   = w;
        e.count = mq.size();
        e.done  = m_loaded && (mq.size() == 0);
        e.err   = m_err;
        for (int k = 0; k < NUM_ENGINE; k++) begin
            e.slot[k] = (k < w) ? mq[k] : '0;
        end
        return e;
    endfunction

    // Apply one cycle of inputs, advance the reference queue, queue the expected post-edge view.
    task automatic step(input bit rst, input bit vld, input clause_t d, input int acc, input bit ld);
        int w;
        int n;
        reset           = rst;
        clause_valid_in = vld;
        clause_in       = d;
        accept_in       = eng_cnt_t'(acc);
        load_done_in    = ld;
        if (rst) begin
            mq.delete();
            m_loaded = 0;
            m_err    = 0;
        end else begin
            bit take;
            w    = min_int(mq.size(), NUM_ENGINE);
            n    = acc;
            take = vld && (mq.size() != DEPTH) && !m_loaded;
            if (acc > w) begin
                n     = w;
                m_err = 1;
            end
            if (vld && m_loaded) m_err = 1;
            if (ld) m_loaded = 1;
            for (int i = 0; i < n; i++) void'(mq.pop_front());
            if (take) mq.push_back(d);
        end
        exp_q.push_back(snapshot());
        @(posedge clock);
        #1;
    endtask

    function automatic clause_t rnd_clause();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return clause_t'(r);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare the DUT view against the oldest queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ready_out",      64'(ready_out),      64'(e.rdy));
                chk("clause_cnt_out", 64'(clause_cnt_out), 64'(e.cnt));
                chk("count_out",      64'(count_out),      64'(e.count));
                chk("done_out",       64'(done_out),       64'(e.done));
                chk("err_out",        64'(err_out),        64'(e.err));
                for (int k = 0; k < NUM_ENGINE; k++) begin
                    chk($sformatf("slot%0d", k), 64'(clause_out[k]), 64'(e.slot[k]));
                end
            end
        end
    end

    initial begin
        clause_t a;
        clause_t b;
        clause_t c;
        // Reset, then idle
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);

        // Three pushes, hold, then retire two
        a = rnd_clause(); b = rnd_clause(); c = rnd_clause();
        step(0, 1, a, 0, 0);
        step(0, 1, b, 0, 0);
        step(0, 1, c, 0, 0);
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 2, 0);
        step(0, 0, '0, 0, 0);

        // Fill to full, refused push, retire, push + retire together
        step(1, 0, '0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, rnd_clause(), 0, 0);
        step(0, 1, rnd_clause(), 0, 0);
        step(0, 1, rnd_clause(), 4, 0);
        step(0, 1, rnd_clause(), 4, 0);
        step(0, 0, '0, 0, 0);

        // Window across the wrap point: rd_ptr lands on 14 with 4 entries
        step(1, 0, '0, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 1, rnd_clause(), 0, 0);
        step(0, 0, '0, 4, 0);
        step(0, 0, '0, 4, 0);
        step(0, 0, '0, 4, 0);
        step(0, 0, '0, 2, 0);
        for (int i = 0; i < 4; i++) step(0, 1, rnd_clause(), 0, 0);
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 1, 0);

        // Over-accept is clamped and flagged
        step(1, 0, '0, 0, 0);
        step(0, 1, rnd_clause(), 0, 0);
        step(0, 1, rnd_clause(), 0, 0);
        step(0, 0, '0, 3, 0);
        step(0, 0, '0, 0, 0);
        step(0, 1, rnd_clause(), 0, 0);

        // Load done, drain, late push, reset
        step(1, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, rnd_clause(), 0, 0);
        step(0, 1, rnd_clause(), 0, 1);
        step(0, 0, '0, 4, 0);
        step(0, 0, '0, 2, 0);
        step(0, 0, '0, 0, 0);
        step(0, 1, rnd_clause(), 0, 0);
        step(1, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);

        // Randomized traffic with occasional protocol errors, load_done and resets
        for (int i = 0; i < 3000; i++) begin
            int w;
            int acc;
            w = min_int(mq.size(), NUM_ENGINE);
            if ($urandom_range(0, 24) == 0) acc = $urandom_range(0, 7);
            else                           acc = $urandom_range(0, w);
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 9) < 7),
                 rnd_clause(),
                 acc,
                 ($urandom_range(0, 249) == 0));
        end

        repeat (3) @(posedge clock);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
